// File: rtl/prm_edge_pkg.sv
// prm_edge_pkg
//   Shared types and defaults for the PRM edge-mask accumulation stage.
//   - prm_acc_state_e : sequencing FSM state encoding
//   - OBS_CODE_W      : width of one obstacle code fed to the checker bank
//   - EDGE_NUM_DEF    : default number of PRM edges (checker instances)
//   - WORD_W_DEF      : default bitmap readout word width
package prm_edge_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        FLUSH = 2'd2,
        DRAIN = 2'd3
    } prm_acc_state_e;

    localparam int OBS_CODE_W   = 15;
    localparam int EDGE_NUM_DEF = 512;
    localparam int WORD_W_DEF   = 32;

endpackage

// File: rtl/prm_popcount.sv
// prm_popcount
//   Population count of a WIDTH-bit vector with one register stage.
//   Ports:
//     clk    in   clock
//     rst_n  in   asynchronous active-low reset
//     clr    in   synchronous clear of the count register (wins over load)
//     load   in   capture popcount(din) into cnt
//     din    in   WIDTH-bit vector to count
//     cnt    out  registered count, $clog2(WIDTH+1) bits
module prm_popcount
    import prm_edge_pkg::*;
#(
    parameter  int WIDTH = EDGE_NUM_DEF,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] sum;

    always_comb begin
        sum = '0;
        for (int i = 0; i < WIDTH; i++) begin
            sum = sum + CNT_W'(din[i]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= sum;
        end
    end

endmodule

// File: rtl/prm_edge_mask_accum.sv
// prm_edge_mask_accum
//   Feeds a frame of obstacle codes to the external combinational checker
//   bank, ORs the returned per-edge masks into a blocked-edge bitmap and
//   streams the bitmap out word-serially.
//
//   Optional feature macro: PRM_EDGE_STAT_EN (adds blocked_cnt popcount).
//
//   Ports:
//     clk          in   sole clock
//     rst_n        in   asynchronous active-low reset
//     frame_start  in   starts a frame; honoured only in IDLE
//     obs_valid    in   obstacle code valid
//     obs_ready    out  block accepts an obstacle code
//     obs_code     in   obstacle code (bit 14 = checker input O .. bit 0 = A)
//     obs_last     in   last code of the frame (qualified by handshake)
//     chk_code     out  registered code driven to every checker
//     chk_mask     in   checker outputs, bit e = edge e blocked
//     map_valid    out  bitmap word valid
//     map_ready    in   downstream accepts word
//     map_data     out  bitmap word, bit j = edge idx*WORD_W+j
//     map_idx      out  word index
//     map_last     out  final word flag
//     busy         out  FSM not in IDLE
//     blocked_cnt  out  blocked-edge total (PRM_EDGE_STAT_EN only)
//
//   state | meaning
//   ------+----------------------------------------------------------------
//   IDLE  | waiting for frame_start; bitmap and word index hold
//   CHECK | accepting codes; after the last handshake obs_ready drops for
//         | one cycle while that code's mask is merged, then -> FLUSH
//   FLUSH | bitmap final; word index cleared, popcount captured
//   DRAIN | streaming bitmap words; last-word handshake -> IDLE
module prm_edge_mask_accum
    import prm_edge_pkg::*;
#(
    parameter  int EDGE_NUM = EDGE_NUM_DEF,
    parameter  int WORD_W   = WORD_W_DEF,
    localparam int WORDS    = EDGE_NUM / WORD_W,
    localparam int IDX_W    = $clog2(WORDS),
    localparam int CNT_W    = $clog2(EDGE_NUM + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  frame_start,
    input  logic                  obs_valid,
    output logic                  obs_ready,
    input  logic [OBS_CODE_W-1:0] obs_code,
    input  logic                  obs_last,
    output logic [OBS_CODE_W-1:0] chk_code,
    input  logic [EDGE_NUM-1:0]   chk_mask,
    output logic                  map_valid,
    input  logic                  map_ready,
    output logic [WORD_W-1:0]     map_data,
    output logic [IDX_W-1:0]      map_idx,
    output logic                  map_last,
    output logic                  busy
`ifdef PRM_EDGE_STAT_EN
    ,
    output logic [CNT_W-1:0]      blocked_cnt
`endif
);

    prm_acc_state_e        state_q, state_d;
    logic                  chk_vld_q;
    logic                  chk_last_q;
    logic [EDGE_NUM-1:0]   bitmap_q;
    logic [IDX_W-1:0]      idx_q;
    logic                  obs_hs;
    logic                  map_hs;
    logic                  frame_go;

    assign obs_hs   = obs_valid && obs_ready;
    assign map_hs   = map_valid && map_ready;
    assign frame_go = (state_q == IDLE) && frame_start;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        obs_ready = 1'b0;
        map_valid = 1'b0;
        case (state_q)
            IDLE: begin
                if (frame_start) begin
                    state_d = CHECK;
                end
            end
            CHECK: begin
                // chk_last_q marks the cycle the final code's mask is on
                // the bank; stop accepting so nothing slips in after it.
                obs_ready = !chk_last_q;
                if (chk_last_q) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                state_d = DRAIN;
            end
            DRAIN: begin
                map_valid = 1'b1;
                if (map_ready && map_last) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy     = (state_q != IDLE);
    assign map_last = (state_q == DRAIN) && (idx_q == IDX_W'(WORDS - 1));
    assign map_idx  = idx_q;
    assign map_data = bitmap_q[idx_q * WORD_W +: WORD_W];

    // Code register toward the bank; chk_vld_q qualifies the cycle in which
    // chk_mask reflects a freshly accepted code.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_code   <= '0;
            chk_vld_q  <= 1'b0;
            chk_last_q <= 1'b0;
        end else begin
            chk_vld_q  <= obs_hs;
            chk_last_q <= obs_hs && obs_last;
            if (obs_hs) begin
                chk_code <= obs_code;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bitmap_q <= '0;
        end else if (frame_go) begin
            bitmap_q <= '0;
        end else if (chk_vld_q) begin
            bitmap_q <= bitmap_q | chk_mask;
        end
    end

    // Word index stops on the last word so map_data keeps showing it in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q <= '0;
        end else if (state_q == FLUSH) begin
            idx_q <= '0;
        end else if (map_hs && !map_last) begin
            idx_q <= idx_q + IDX_W'(1);
        end
    end

`ifdef PRM_EDGE_STAT_EN
    prm_popcount #(
        .WIDTH (EDGE_NUM)
    ) u_popcount (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (frame_go),
        .load  (state_q == FLUSH),
        .din   (bitmap_q),
        .cnt   (blocked_cnt)
    );
`endif

endmodule

// File: tb/tb_prm_edge_mask_accum.sv
module tb_prm_edge_mask_accum;

    localparam int EDGE_NUM = 512;
    localparam int WORD_W   = 32;
    localparam int WORDS    = 16;
    localparam int IDX_W    = 4;
    localparam int CNT_W    = 10;
    // Driven whenever no code was accepted last cycle; must never reach the bitmap.
    localparam logic [EDGE_NUM-1:0] JUNK = {WORDS{32'h0010_0000}};

    logic                clk;
    logic                rst_n;
    logic                frame_start;
    logic                obs_valid;
    logic                obs_ready;
    logic [14:0]         obs_code;
    logic                obs_last;
    logic [14:0]         chk_code;
    logic [EDGE_NUM-1:0] chk_mask;
    logic                map_valid;
    logic                map_ready;
    logic [WORD_W-1:0]   map_data;
    logic [IDX_W-1:0]    map_idx;
    logic                map_last;
    logic                busy;
`ifdef PRM_EDGE_STAT_EN
    logic [CNT_W-1:0]    blocked_cnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0] exp_w [WORDS];
    logic [31:0] got_w [WORDS];
    logic [14:0] codes [8];
    logic        hs_q;
    int          dcyc;

    prm_edge_mask_accum dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .frame_start (frame_start),
        .obs_valid   (obs_valid),
        .obs_ready   (obs_ready),
        .obs_code    (obs_code),
        .obs_last    (obs_last),
        .chk_code    (chk_code),
        .chk_mask    (chk_mask),
        .map_valid   (map_valid),
        .map_ready   (map_ready),
        .map_data    (map_data),
        .map_idx     (map_idx),
        .map_last    (map_last),
        .busy        (busy)
`ifdef PRM_EDGE_STAT_EN
        ,
        .blocked_cnt (blocked_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench model of the checker bank.
    function automatic logic [EDGE_NUM-1:0] mask_of(input logic [14:0] c);
        logic [EDGE_NUM-1:0] m;
        m = '0;
        case (c)
            15'h4A21: m[480] = 1'b1;
            15'h0001: begin m[0] = 1'b1; m[1] = 1'b1; end
            15'h0002: begin m[1] = 1'b1; m[33] = 1'b1; end
            15'h0003: m[511] = 1'b1;
            default:  m = '0;
        endcase
        return m;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) hs_q <= 1'b0;
        else        hs_q <= obs_valid && obs_ready;
    end

    always_comb chk_mask = hs_q ? mask_of(chk_code) : JUNK;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic build_exp(input int n);
        logic [EDGE_NUM-1:0] bm;
        bm = '0;
        for (int i = 0; i < n; i++) bm = bm | mask_of(codes[i]);
        for (int w = 0; w < WORDS; w++) exp_w[w] = bm[w*WORD_W +: WORD_W];
    endtask

    // Starts at a negedge with the DUT in IDLE; returns at the negedge after the last handshake.
    task automatic send_frame(input int n, input bit gap, input bit fs_mid);
        int b;
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        for (int i = 0; i < n; i++) begin
            obs_valid   = 1'b1;
            obs_code    = codes[i];
            obs_last    = (i == n - 1);
            frame_start = fs_mid && (i == 1);
            b = 0;
            while (!obs_ready && b < 20) begin
                @(negedge clk);
                b++;
            end
            if (b >= 20) check_val("obs_ready timeout", 64'(b), 64'd0);
            @(negedge clk);
            obs_valid   = 1'b0;
            obs_last    = 1'b0;
            frame_start = 1'b0;
            check_val("chk_code after accept", 64'(chk_code), 64'(codes[i]));
            if (fs_mid && i == 1) check_val("busy after ignored start", 64'(busy), 64'd1);
            if (gap && i != n - 1) begin
                @(negedge clk);
                check_val("chk_code held in gap", 64'(chk_code), 64'(codes[i]));
            end
        end
    endtask

    task automatic drain_frame(input bit toggle, input bit fs_pulse, output int cycles);
        int k;
        int cyc;
        bit rdy;
        bit hold_pend;
        bit fs_done;
        logic [31:0] hold_d;
        k = 0; cyc = 0; hold_pend = 0; fs_done = 0; hold_d = '0;
        while (k < WORDS && cyc < 200) begin
            frame_start = 1'b0;
            rdy = toggle ? ((cyc % 2) == 1) : 1'b1;
            map_ready = rdy;
            if (map_valid) begin
                if (fs_pulse && !fs_done) begin
                    frame_start = 1'b1;
                    fs_done = 1'b1;
                end
                check_val("map_idx", 64'(map_idx), 64'(k));
                check_val("map_last", 64'(map_last), 64'(k == WORDS - 1));
                if (hold_pend) check_val("map_data held", 64'(map_data), 64'(hold_d));
                hold_pend = !rdy;
                hold_d    = map_data;
                if (rdy) begin
                    got_w[k] = map_data;
                    k++;
                end
            end
            @(negedge clk);
            cyc++;
        end
        frame_start = 1'b0;
        map_ready   = 1'b0;
        if (k < WORDS) check_val("drain timeout", 64'(k), 64'(WORDS));
        check_val("busy after drain", 64'(busy), 64'd0);
        for (int w = 0; w < WORDS; w++)
            check_val($sformatf("word%0d", w), 64'(got_w[w]), 64'(exp_w[w]));
        cycles = cyc;
    endtask

    initial begin
        rst_n = 1'b0; frame_start = 1'b0; obs_valid = 1'b0; obs_code = '0;
        obs_last = 1'b0; map_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_val("rst obs_ready", 64'(obs_ready), 64'd0);
        check_val("rst map_valid", 64'(map_valid), 64'd0);
        check_val("rst map_last", 64'(map_last), 64'd0);
        check_val("rst busy", 64'(busy), 64'd0);
        check_val("rst chk_code", 64'(chk_code), 64'd0);
        check_val("rst map_data", 64'(map_data), 64'd0);
`ifdef PRM_EDGE_STAT_EN
        check_val("rst blocked_cnt", 64'(blocked_cnt), 64'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        // Single code, minimum-latency frame
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        check_val("t1 busy", 64'(busy), 64'd1);
        obs_valid = 1'b1; obs_code = 15'h4A21; obs_last = 1'b1;
        check_val("t1 obs_ready", 64'(obs_ready), 64'd1);
        @(negedge clk);
        obs_valid = 1'b0; obs_last = 1'b0;
        check_val("t1 ready low after last", 64'(obs_ready), 64'd0);
        check_val("t1 chk_code", 64'(chk_code), 64'h4A21);
        @(negedge clk);
        check_val("t1 no valid in flush", 64'(map_valid), 64'd0);
        @(negedge clk);
        check_val("t1 valid after flush", 64'(map_valid), 64'd1);
`ifdef PRM_EDGE_STAT_EN
        check_val("t1 blocked_cnt", 64'(blocked_cnt), 64'd1);
`endif
        for (int w = 0; w < WORDS; w++) exp_w[w] = 32'h0;
        exp_w[15] = 32'h0000_0001;
        drain_frame(1'b0, 1'b0, dcyc);
        check_val("t1 drain cycles", 64'(dcyc), 64'd16);
        repeat (3) @(negedge clk);
        check_val("t1 idle map_idx held", 64'(map_idx), 64'd15);
        check_val("t1 idle bitmap held", 64'(map_data), 64'h1);

        // OR accumulation, frame_start ignored in CHECK and DRAIN, backpressure
        codes[0] = 15'h0001; codes[1] = 15'h0002; codes[2] = 15'h0003;
        build_exp(3);
        check_val("t2 model w0", 64'(exp_w[0]), 64'h3);
        send_frame(3, 1'b0, 1'b1);
        drain_frame(1'b1, 1'b1, dcyc);
        check_val("t2 word0", 64'(got_w[0]), 64'h3);
        check_val("t2 word1", 64'(got_w[1]), 64'h2);
        check_val("t2 word15", 64'(got_w[15]), 64'h8000_0000);
`ifdef PRM_EDGE_STAT_EN
        check_val("t2 blocked_cnt", 64'(blocked_cnt), 64'd4);
`endif

        // obs_valid in IDLE is not acknowledged
        obs_valid = 1'b1; obs_code = 15'h4A21;
        for (int i = 0; i < 3; i++) begin
            check_val("idle obs_ready", 64'(obs_ready), 64'd0);
            @(negedge clk);
        end
        obs_valid = 1'b0;
        check_val("idle chk_code held", 64'(chk_code), 64'h0003);
        check_val("idle busy", 64'(busy), 64'd0);

        // Reset mid-frame
        frame_start = 1'b1;
        @(negedge clk);
        frame_start = 1'b0;
        obs_valid = 1'b1; obs_code = 15'h0001; obs_last = 1'b0;
        repeat (5) @(negedge clk);
        obs_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check_val("mid rst busy", 64'(busy), 64'd0);
        check_val("mid rst obs_ready", 64'(obs_ready), 64'd0);
        check_val("mid rst map_valid", 64'(map_valid), 64'd0);
        check_val("mid rst chk_code", 64'(chk_code), 64'd0);
        check_val("mid rst map_data", 64'(map_data), 64'd0);
        check_val("mid rst map_idx", 64'(map_idx), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        codes[0] = 15'h4A21;
        build_exp(1);
        send_frame(1, 1'b0, 1'b0);
        drain_frame(1'b0, 1'b0, dcyc);
        check_val("post rst word0", 64'(got_w[0]), 64'h0);

        // Gapped stream matches gap-free result
        codes[0] = 15'h0001; codes[1] = 15'h0002; codes[2] = 15'h0003;
        build_exp(3);
        send_frame(3, 1'b1, 1'b0);
        drain_frame(1'b0, 1'b0, dcyc);
        check_val("gap word0", 64'(got_w[0]), 64'h3);
        check_val("gap word1", 64'(got_w[1]), 64'h2);
        check_val("gap word15", 64'(got_w[15]), 64'h8000_0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
